buffer_sequencer: RTL and testbench

Controller that sequences the 8 pattern buffers. It walks a play list stored in the sequence buffer and drives `bufp` to each listed buffer for a programmed number of `step` pulses. It also arbitrates the single field port (`fieldp`/`field_byte`/`field_write`) between its own list fetches and the processor core. It sits between the core and the buffer bank, and owns the bank's `bufp`, `fieldp` and `field_write` inputs.

---
 rtl/bufseq_pkg.sv | 37 +++
 rtl/bufseq_dwell_cnt.sv | 38 +++
 rtl/buffer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_buffer_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bufseq_pkg.sv
// Shared types and constants for the buffer sequencer.
// The play list lives in buffer SEQ_BUF; each entry is two bytes
// (index/END byte, then dwell byte).
package bufseq_pkg;

   localparam int BUFFER_WIDTH = 8;
   localparam int BUFFER_SIZE  = 32;
   localparam int NO_BUFS      = 8;
   localparam int MAX_ENTRIES  = BUFFER_SIZE / 2;

   localparam int BUFP_W   = $clog2(NO_BUFS);
   localparam int FIELDP_W = $clog2(BUFFER_SIZE);
   localparam int PTR_W    = $clog2(MAX_ENTRIES);

   localparam logic [BUFP_W-1:0] SEQ_BUF = '0;

   // Index byte layout: bit 7 marks a terminator, bits [2:0] select the buffer.
   localparam int END_BIT = 7;
   localparam int IDX_W   = 3;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_IDX,
      FETCH_DWELL,
      RUN,
      DONE
   } bufseq_state_e;

   // Last counter value of an entry; a dwell of 0 plays like a dwell of 1.
   function automatic logic [BUFFER_WIDTH-1:0] dwell_last(input logic [BUFFER_WIDTH-1:0] dwell);
      if (dwell == '0) begin
         return '0;
      end
      return dwell - 1'b1;
   endfunction

endpackage

// File: rtl/bufseq_dwell_cnt.sv
// Step counter for one play-list entry. tc_o fires on the step that
// completes the programmed dwell (counter = max(dwell,1)-1 with en_i high).
module bufseq_dwell_cnt
   import bufseq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic [BUFFER_WIDTH-1:0] dwell_i,
   output logic                    tc_o
);

   logic [BUFFER_WIDTH-1:0] cnt_q;
   logic [BUFFER_WIDTH-1:0] cnt_d;

   // Next count: clear wins over a step.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i && (cnt_q == dwell_last(dwell_i));

endmodule

// File: rtl/buffer_sequencer.sv
// Play-list sequencer for the pattern buffer bank.
// Walks the list in buffer SEQ_BUF, drives bufp for each entry's dwell,
// and shares the bank's field port with the core (the core is locked out
// only during the two fetch cycles of each entry).
// Optional feature: define BUFSEQ_LOOP_EN to add the loop input, which
// restarts the list at its end instead of finishing.
//
// Core handshake: core_gnt is a combinational grant; a core request
// (core_field_write/core_fieldp) must be held until core_gnt is seen high,
// and field_write is only ever core_field_write qualified by core_gnt.
module buffer_sequencer
   import bufseq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    step,
`ifdef BUFSEQ_LOOP_EN
   input  logic                    loop,
`endif
   output logic [BUFP_W-1:0]       bufp,
   output logic [FIELDP_W-1:0]     fieldp,
   input  logic [BUFFER_WIDTH-1:0] field_byte,
   output logic                    field_write,
   input  logic [FIELDP_W-1:0]     core_fieldp,
   input  logic                    core_field_write,
   output logic                    core_gnt,
   output logic                    busy,
   output logic                    done,
   output logic [PTR_W-1:0]        cur_entry
);

   bufseq_state_e           state_q, state_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [BUFP_W-1:0]       bufp_q, bufp_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BUFFER_WIDTH-1:0] dwell_q, dwell_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    cnt_clr;
   logic                    cnt_en;
   logic                    cnt_tc;
   logic                    loop_w;
   logic                    last_entry;

`ifdef BUFSEQ_LOOP_EN
   assign loop_w = loop;
`else
   assign loop_w = 1'b0;
`endif

   assign last_entry = (ptr_q == PTR_W'(MAX_ENTRIES - 1));
   assign cnt_en     = (state_q == RUN) && step;

   bufseq_dwell_cnt u_dwell_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .dwell_i (dwell_q),
      .tc_o    (cnt_tc)
   );

   // Next-state and registered-output logic; stop overrides everything.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      bufp_d  = bufp_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      cnt_clr = 1'b0;
      if (stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = FETCH_IDX;
                  ptr_d   = '0;
                  bufp_d  = SEQ_BUF;
               end
            end
            FETCH_IDX: begin
               if (field_byte[END_BIT]) begin
                  if (loop_w) begin
                     state_d = FETCH_IDX;
                     ptr_d   = '0;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  idx_d   = field_byte[IDX_W-1:0];
                  state_d = FETCH_DWELL;
               end
            end
            FETCH_DWELL: begin
               dwell_d = field_byte;
               cnt_clr = 1'b1;
               bufp_d  = idx_q;
               state_d = RUN;
            end
            RUN: begin
               if (cnt_tc) begin
                  ptr_d = ptr_q + 1'b1;
                  // Running off entry 15 is an implicit end of list.
                  if (last_entry && !loop_w) begin
                     state_d = DONE;
                  end else begin
                     state_d = FETCH_IDX;
                     bufp_d  = SEQ_BUF;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         bufp_q  <= SEQ_BUF;
         idx_q   <= '0;
         dwell_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         bufp_q  <= bufp_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Field port mux: the sequencer owns it only while fetching list bytes.
   always_comb begin
      core_gnt    = 1'b1;
      fieldp      = core_fieldp;
      field_write = 1'b0;
      case (state_q)
         FETCH_IDX: begin
            core_gnt = 1'b0;
            fieldp   = {ptr_q, 1'b0};
         end
         FETCH_DWELL: begin
            core_gnt = 1'b0;
            fieldp   = {ptr_q, 1'b1};
         end
         default: begin
            core_gnt = 1'b1;
            fieldp   = core_fieldp;
         end
      endcase
      field_write = core_gnt && core_field_write;
   end

   assign bufp      = bufp_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cur_entry = ptr_q;

endmodule

// File: tb/tb_buffer_sequencer.sv
// Bench for buffer_sequencer: directed scenarios, a list-walking reference
// model compared every cycle, plus literal spot checks.
module tb_buffer_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       step;
`ifdef BUFSEQ_LOOP_EN
   logic       loop;
`endif
   logic [2:0] bufp;
   logic [4:0] fieldp;
   logic [7:0] field_byte;
   logic       field_write;
   logic [4:0] core_fieldp;
   logic       core_field_write;
   logic       core_gnt;
   logic       busy;
   logic       done;
   logic [3:0] cur_entry;

   logic [7:0] seq_mem [32];

   int checks = 0;
   int errors = 0;

   // clock
   always #5 clk = ~clk;

   // Bank: buffer 0 comes from seq_mem, other buffers return a fixed pattern.
   assign field_byte = (bufp == 3'd0) ? seq_mem[fieldp] : {bufp, fieldp};

   buffer_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .stop             (stop),
      .step             (step),
`ifdef BUFSEQ_LOOP_EN
      .loop             (loop),
`endif
      .bufp             (bufp),
      .fieldp           (fieldp),
      .field_byte       (field_byte),
      .field_write      (field_write),
      .core_fieldp      (core_fieldp),
      .core_field_write (core_field_write),
      .core_gnt         (core_gnt),
      .busy             (busy),
      .done             (done),
      .cur_entry        (cur_entry)
   );

   // ---------------- reference model ----------------
   localparam int P_IDLE  = 0;
   localparam int P_IDX   = 1;
   localparam int P_DWELL = 2;
   localparam int P_PLAY  = 3;
   localparam int P_FIN   = 4;

   int m_phase = P_IDLE;
   int m_ptr   = 0;
   int m_bufp  = 0;
   int m_idx   = 0;
   int m_left  = 0;

   function automatic bit loop_in();
`ifdef BUFSEQ_LOOP_EN
      return loop;
`else
      return 1'b0;
`endif
   endfunction

   // Model update on each rising edge, from the list contents directly.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = P_IDLE; m_ptr = 0; m_bufp = 0; m_idx = 0; m_left = 0;
      end else if (stop) begin
         m_phase = P_IDLE;
      end else begin
         case (m_phase)
            P_IDLE: if (start) begin
               m_phase = P_IDX; m_ptr = 0; m_bufp = 0;
            end
            P_IDX: begin
               if (seq_mem[2*m_ptr][7]) begin
                  if (loop_in()) begin m_ptr = 0; m_phase = P_IDX; end
                  else m_phase = P_FIN;
               end else begin
                  m_idx = seq_mem[2*m_ptr] % 8;
                  m_phase = P_DWELL;
               end
            end
            P_DWELL: begin
               m_left = (seq_mem[2*m_ptr+1] == 0) ? 1 : int'(seq_mem[2*m_ptr+1]);
               m_bufp = m_idx;
               m_phase = P_PLAY;
            end
            P_PLAY: if (step) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  if (m_ptr == 15) begin
                     m_ptr = 0;
                     if (loop_in()) begin m_phase = P_IDX; m_bufp = 0; end
                     else m_phase = P_FIN;
                  end else begin
                     m_ptr = m_ptr + 1; m_phase = P_IDX; m_bufp = 0;
                  end
               end
            end
            default: m_phase = P_IDLE;
         endcase
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic       exp_gnt;
      logic [4:0] exp_fp;
      exp_gnt = !(m_phase == P_IDX || m_phase == P_DWELL);
      if (m_phase == P_IDX)        exp_fp = 5'(2 * m_ptr);
      else if (m_phase == P_DWELL) exp_fp = 5'(2 * m_ptr + 1);
      else                         exp_fp = core_fieldp;
      check("m_bufp",      32'(bufp),        32'(m_bufp));
      check("m_busy",      32'(busy),        32'(m_phase != P_IDLE));
      check("m_done",      32'(done),        32'(m_phase == P_FIN));
      check("m_cur_entry", 32'(cur_entry),   32'(m_ptr % 16));
      check("m_core_gnt",  32'(core_gnt),    32'(exp_gnt));
      check("m_fieldp",    32'(fieldp),      32'(exp_fp));
      check("m_field_wr",  32'(field_write), 32'(exp_gnt & core_field_write));
   endtask

   // One cycle: compare on the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #1;
   endtask

   task automatic do_step();
      step = 1'b1; tick(); step = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic clear_list();
      for (int i = 0; i < 32; i++) seq_mem[i] = 8'h00;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
      core_fieldp = 5'd0; core_field_write = 1'b0;
`ifdef BUFSEQ_LOOP_EN
      loop = 1'b0;
`endif
      clear_list();

      // reset state
      tick(); tick();
      check("rst_bufp", 32'(bufp), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cur_entry", 32'(cur_entry), 32'd0);
      check("rst_core_gnt", 32'(core_gnt), 32'd1);
      core_fieldp = 5'd9; core_field_write = 1'b1; #1;
      check("rst_fieldp_pass", 32'(fieldp), 32'd9);
      check("rst_fwrite_pass", 32'(field_write), 32'd1);
      core_field_write = 1'b0; core_fieldp = 5'd0;
      rst_n = 1'b1;
      tick();

      // list [(3,2),(5,1),END]
      seq_mem[0] = 8'h03; seq_mem[1] = 8'd2;
      seq_mem[2] = 8'h05; seq_mem[3] = 8'd1;
      seq_mem[4] = 8'h80;
      do_start();
      check("t1_fetch_bufp", 32'(bufp), 32'd0);
      check("t1_fetch_busy", 32'(busy), 32'd1);
      check("t1_fetch_gnt", 32'(core_gnt), 32'd0);
      check("t1_fetch_fieldp", 32'(fieldp), 32'd0);
      tick();
      check("t1_dwell_fieldp", 32'(fieldp), 32'd1);
      check("t1_dwell_bufp", 32'(bufp), 32'd0);
      tick();
      check("t1_run_bufp", 32'(bufp), 32'd3);
      do_start();                      // ignored outside IDLE
      do_step();
      check("t1_hold_bufp", 32'(bufp), 32'd3);
      tick();
      do_step();
      check("t1_switch_bufp", 32'(bufp), 32'd0);
      check("t1_switch_entry", 32'(cur_entry), 32'd1);
      tick(); tick();
      check("t1_run2_bufp", 32'(bufp), 32'd5);
      do_step();
      tick();
      check("t1_done", 32'(done), 32'd1);
      tick();
      check("t1_done_gone", 32'(done), 32'd0);
      check("t1_busy_fall", 32'(busy), 32'd0);
      tick();

      // empty list
      clear_list();
      seq_mem[0] = 8'h80;
      do_start();
      check("t2_n1_busy", 32'(busy), 32'd1);
      check("t2_n1_done", 32'(done), 32'd0);
      tick();
      check("t2_n2_done", 32'(done), 32'd1);
      check("t2_n2_bufp", 32'(bufp), 32'd0);
      tick();
      check("t2_n3_done", 32'(done), 32'd0);
      check("t2_n3_busy", 32'(busy), 32'd0);
      tick();

      // 16 entries, no END, dwell alternating 0/1
      for (int i = 0; i < 16; i++) begin
         seq_mem[2*i]   = 8'(i % 8) | ((i % 2 == 1) ? 8'h38 : 8'h00);
         seq_mem[2*i+1] = (i % 2 == 1) ? 8'd1 : 8'd0;
      end
      do_start();
      for (int e = 0; e < 16; e++) begin
         tick(); tick();
         if (e == 15) check("t3_last_entry", 32'(cur_entry), 32'd15);
         do_step();
      end
      check("t3_wrap_done", 32'(done), 32'd1);
      check("t3_wrap_entry", 32'(cur_entry), 32'd0);
      check("t3_wrap_bufp", 32'(bufp), 32'd7);
      tick();
      check("t3_busy_fall", 32'(busy), 32'd0);
      tick();

      // core write across an entry switch
      clear_list();
      seq_mem[0] = 8'h03; seq_mem[1] = 8'd1;
      seq_mem[2] = 8'h06; seq_mem[3] = 8'd1;
      seq_mem[4] = 8'h80;
      do_start();
      tick(); tick();
      core_field_write = 1'b1; core_fieldp = 5'd4; #1;
      check("t4_run_fw", 32'(field_write), 32'd1);
      check("t4_run_fp", 32'(fieldp), 32'd4);
      do_step();
      check("t4_fetch1_fw", 32'(field_write), 32'd0);
      check("t4_fetch1_gnt", 32'(core_gnt), 32'd0);
      check("t4_fetch1_fp", 32'(fieldp), 32'd2);
      tick();
      check("t4_fetch2_fw", 32'(field_write), 32'd0);
      check("t4_fetch2_fp", 32'(fieldp), 32'd3);
      tick();
      check("t4_run2_fw", 32'(field_write), 32'd1);
      check("t4_run2_fp", 32'(fieldp), 32'd4);
      check("t4_run2_bufp", 32'(bufp), 32'd6);
      core_field_write = 1'b0;
      do_step();
      tick();
      check("t4_done", 32'(done), 32'd1);
      tick(); tick();

      // stop together with step during RUN
      clear_list();
      seq_mem[0] = 8'h04; seq_mem[1] = 8'd3;
      seq_mem[2] = 8'h80;
      do_start();
      tick(); tick();
      do_step();
      tick();
      step = 1'b1; stop = 1'b1; tick(); step = 1'b0; stop = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_bufp_held", 32'(bufp), 32'd4);
      tick(); tick();
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      check("t5_stop_over_start", 32'(busy), 32'd0);
      tick();

`ifdef BUFSEQ_LOOP_EN
      // looping list [(2,1),END]
      clear_list();
      seq_mem[0] = 8'h02; seq_mem[1] = 8'd1;
      seq_mem[2] = 8'h80;
      loop = 1'b1;
      do_start();
      for (int k = 0; k < 3; k++) begin
         tick(); tick();
         check("t6_run_bufp", 32'(bufp), 32'd2);
         do_step();
         check("t6_gap_bufp", 32'(bufp), 32'd0);
         tick();
         check("t6_restart_entry", 32'(cur_entry), 32'd0);
         check("t6_no_done", 32'(done), 32'd0);
         check("t6_busy", 32'(busy), 32'd1);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      loop = 1'b0;
      check("t6_stopped", 32'(busy), 32'd0);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
